// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared constants, command ROM and sequencer states for the SSD1306 streamer.
// Revision 1.0
`default_nettype none

package ssd1306_pkg;

  localparam int CMD_BYTES = 6;
  localparam int FB_BYTES  = 512;

  // Column 0..127, page 0..3; the panel is left in horizontal addressing mode.
  localparam logic [7:0] CMD_ROM [CMD_BYTES] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_END    = 3'd5
  } state_e;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    return (idx < 3'd6) ? CMD_ROM[idx] : 8'h00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: mode-0 SPI byte serializer, MSB first, CLK_DIV clk cycles per SCLK half-period.
// Revision 1.0
`default_nettype none

module spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       done_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          w_phase_end;

  assign w_phase_end = active_q && (div_q == DIV_LAST);
  // Asserted on the last cycle of bit 0's high phase so the parent can leave SHIFT on time.
  assign done_o      = w_phase_end && sclk_q && (bit_cnt_q == 3'd0);
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;

  always_comb begin
    active_d  = active_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    if (start_i) begin
      active_d  = 1'b1;
      sclk_d    = 1'b0;
      mosi_d    = data_i[7];
      shreg_d   = data_i;
      bit_cnt_d = 3'd7;
      div_d     = '0;
    end else if (active_q) begin
      if (w_phase_end) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (bit_cnt_q == 3'd0) begin
            active_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            mosi_d    = shreg_q[6];
            shreg_d   = {shreg_q[6:0], 1'b0};
          end
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      div_q     <= '0;
    end else begin
      active_q  <= active_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssd1306_fb_streamer.sv
// ssd1306_fb_streamer: on a refresh edge, sends the addressing preamble then all framebuffer bytes over SPI.
// Revision 1.0
`default_nettype none

module ssd1306_fb_streamer #(
  parameter int CLK_DIV   = 2,
  parameter int FB_BYTES  = ssd1306_pkg::FB_BYTES,
  parameter int CMD_BYTES = ssd1306_pkg::CMD_BYTES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh,
  input  logic       gfx_ready,
  output logic [8:0] ssd1306_addr,
  output logic       rd,
  input  logic [7:0] ssd1306_out,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_dc,
  output logic       busy,
  output logic       done
);

  import ssd1306_pkg::*;

  localparam int TOTAL = CMD_BYTES + FB_BYTES;
  localparam int CW    = $clog2(TOTAL);

  state_e        state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic          pending_q, pending_d;
  logic          refresh_r_q;
  logic          cs_q, cs_d;
  logic          dc_q, dc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          w_rise;
  logic          w_is_cmd;
  logic          w_load;
  logic [8:0]    w_fb_idx;
  logic          w_tx_start;
  logic [7:0]    w_tx_data;
  logic          w_tx_done;

  assign w_rise     = refresh & ~refresh_r_q;
  assign w_is_cmd   = byte_cnt_q < CW'(CMD_BYTES);
  assign w_load     = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign w_fb_idx   = 9'(byte_cnt_q - CW'(CMD_BYTES));
  // Address is held across both load cycles so read data is valid during LOAD_B.
  assign rd           = w_load && !w_is_cmd;
  assign ssd1306_addr = rd ? w_fb_idx : 9'd0;
  assign w_tx_start = (state_q == ST_LOAD_B);
  assign w_tx_data  = w_is_cmd ? cmd_byte(byte_cnt_q[2:0]) : ssd1306_out;

  assign spi_cs = cs_q;
  assign spi_dc = dc_q;
  assign busy   = busy_q;
  assign done   = done_q;

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start_i (w_tx_start),
    .data_i  (w_tx_data),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi),
    .done_o  (w_tx_done)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pending_d  = pending_q;
    cs_d       = cs_q;
    dc_d       = dc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_rise) pending_d = 1'b1;
        if (pending_q && gfx_ready) begin
          state_d   = ST_START;
          pending_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_START: begin
        cs_d       = 1'b0;
        byte_cnt_d = '0;
        state_d    = ST_LOAD_A;
      end
      ST_LOAD_A: begin
        dc_d    = !w_is_cmd;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_tx_done) begin
          if (byte_cnt_q == CW'(TOTAL - 1)) begin
            cs_d    = 1'b1;
            state_d = ST_END;
          end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
            state_d    = ST_LOAD_A;
          end
        end
      end
      ST_END: begin
        dc_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      pending_q   <= 1'b0;
      refresh_r_q <= 1'b0;
      cs_q        <= 1'b1;
      dc_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pending_q   <= pending_d;
      refresh_r_q <= refresh;
      cs_q        <= cs_d;
      dc_q        <= dc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssd1306_fb_streamer.sv
// tb_ssd1306_fb_streamer: scoreboard bench for the SSD1306 framebuffer streamer.
// Revision 1.0
`default_nettype none

module tb_ssd1306_fb_streamer;

  localparam int CLK_DIV      = 2;
  localparam int FRAME_BYTES  = 518;
  localparam int FRAME_CS_LOW = 17612;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh = 1'b0;
  logic       gfx_ready = 1'b0;
  logic [8:0] ssd1306_addr;
  logic       rd;
  logic [7:0] ssd1306_out;
  logic       spi_cs, spi_sclk, spi_mosi, spi_dc, busy, done;

  always #5 clk = ~clk;

  ssd1306_fb_streamer #(
    .CLK_DIV   (CLK_DIV),
    .FB_BYTES  (512),
    .CMD_BYTES (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .refresh      (refresh),
    .gfx_ready    (gfx_ready),
    .ssd1306_addr (ssd1306_addr),
    .rd           (rd),
    .ssd1306_out  (ssd1306_out),
    .spi_cs       (spi_cs),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_dc       (spi_dc),
    .busy         (busy),
    .done         (done)
  );

  logic [7:0] fb [512];
  logic [7:0] cmd_exp [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};
  logic [8:0] exp_q [$];

  // Framebuffer read port with one cycle of latency; poison value when not read.
  always @(posedge clk) ssd1306_out <= rd ? fb[ssd1306_addr] : 8'hEE;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int frame_bytes = 0;
  int next_addr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: deserialises SPI on sclk rises and checks read-port and frame timing.
  logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_rd = 1'b0, prev_mosi = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [8:0] e;
  logic [8:0] rd_addr = 9'd0;
  int         bit_n = 0, cs_len = 0, rd_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      bit_n  = 0;
      cs_len = 0;
    end else begin
      if (done) done_cnt++;
      if (!spi_cs) begin
        if (prev_cs) begin
          cs_len = 1; frame_bytes = 0; next_addr = 0; bit_n = 0;
        end else begin
          cs_len++;
        end
      end else if (!prev_cs) begin
        check("cs_low_cycles", cs_len, FRAME_CS_LOW);
        check("bytes_per_frame", frame_bytes, FRAME_BYTES);
        check("addr_count", next_addr, 512);
      end
      if (spi_sclk && !prev_sclk) begin
        check("cs_low_at_sclk", spi_cs, 0);
        sh = {sh[6:0], spi_mosi};
        bit_n++;
        if (bit_n == 8) begin
          bit_n = 0;
          frame_bytes++;
          check("sb_entry_available", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d_dc", frame_bytes - 1), spi_dc, e[8]);
            check($sformatf("byte%0d_data", frame_bytes - 1), sh, e[7:0]);
          end
        end
      end
      if (spi_sclk && prev_sclk) check("mosi_stable_high", spi_mosi, prev_mosi);
      if (rd) begin
        check("cs_low_at_rd", spi_cs, 0);
        if (!prev_rd) begin
          check("rd_addr_seq", ssd1306_addr, next_addr);
          check("rd_after_cmds", frame_bytes, 6 + next_addr);
          rd_len  = 1;
          rd_addr = ssd1306_addr;
        end else begin
          rd_len++;
          check("rd_addr_hold", ssd1306_addr, rd_addr);
        end
      end else if (prev_rd) begin
        check("rd_high_cycles", rd_len, 2);
        next_addr++;
      end
    end
    prev_cs   = spi_cs;
    prev_sclk = spi_sclk;
    prev_rd   = rd;
    prev_mosi = spi_mosi;
  end

  task automatic push_frame();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, cmd_exp[i]});
    for (int i = 0; i < 512; i++) exp_q.push_back({1'b1, fb[i]});
  endtask

  task automatic pulse_refresh();
    @(posedge clk); #1 refresh = 1'b1;
    @(posedge clk); #1 refresh = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (done_cnt >= target) break;
    end
    check("done_count", done_cnt, target);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 512; i++) fb[i] = 8'(i * 7 + 3);
    fb[0]   = 8'hA5;
    fb[511] = 8'h3C;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", spi_cs, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_dc", spi_dc, 0);
    check("rst_rd", rd, 0);
    check("rst_addr", ssd1306_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Frame 1: gfx already idle.
    gfx_ready = 1'b1;
    push_frame();
    pulse_refresh();
    wait_done(1, 20000);
    check("f1_queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check("f1_busy_after", busy, 0);
    check("f1_cs_after", spi_cs, 1);

    // Frame 2: refresh while gfx busy, then a dropped mid-frame refresh.
    for (int i = 1; i < 511; i++) fb[i] = ~fb[i];
    gfx_ready = 1'b0;
    push_frame();
    pulse_refresh();
    repeat (50) @(posedge clk);
    #1;
    check("f2_wait_cs", spi_cs, 1);
    check("f2_wait_busy", busy, 0);
    gfx_ready = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!spi_cs) break;
    end
    check("f2_cs_latency", n, 2);
    check("f2_busy_started", busy, 1);
    repeat (3000) @(posedge clk);
    pulse_refresh();
    wait_done(2, 20000);
    check("f2_queue_drained", exp_q.size(), 0);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("f2_no_extra_done", done_cnt, 2);
    check("f2_no_extra_frame_busy", busy, 0);
    check("f2_no_extra_frame_cs", spi_cs, 1);

    // Frame 3: reset during byte 100's shift.
    push_frame();
    pulse_refresh();
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (!spi_cs && frame_bytes == 100 && spi_sclk) break;
    end
    check("abort_point_reached", frame_bytes, 100);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("abort_cs", spi_cs, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_rd", rd, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    repeat (100) @(posedge clk);
    check("abort_no_done", done_cnt, 2);

    // Frame 4: clean frame after the abort.
    for (int i = 1; i < 511; i++) fb[i] = 8'(i) ^ 8'h96;
    push_frame();
    pulse_refresh();
    wait_done(3, 20000);
    check("f4_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssd1306_fb_streamer.md
Name: ssd1306_fb_streamer

Overview:
- Reads the 128x32 monochrome framebuffer through the gfx unit's read port (ssd1306_addr / rd / ssd1306_out) and streams it to an SSD1306 OLED over 4-wire write-only SPI.
- Each frame sends a 6-byte addressing command preamble (dc=0), then 512 framebuffer bytes (dc=1) in address order 0..511.
- Sits between the gfx unit and the top-level OLED pins; it is the consumer end of the framebuffer interface.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
- FB_BYTES, 512, framebuffer bytes per frame (128*32/8).
- CMD_BYTES, 6, preamble length.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- refresh  in  1  frame request; rising edge starts a frame.
- gfx_ready  in  1  gfx unit idle (state 0); a frame starts only while this is high.
- ssd1306_addr  out  9  framebuffer read address.
- rd  out  1  framebuffer read strobe; overrides the gfx unit's address mux.
- ssd1306_out  in  8  framebuffer read data, valid 1 cycle after rd/addr (tri-stated while rd=0).
- spi_cs  out  1  chip select, active low.
- spi_sclk  out  1  SPI clock, mode 0, idle low.
- spi_mosi  out  1  serial data, MSB first.
- spi_dc  out  1  0=command, 1=data.
- busy  out  1  high from frame start until spi_cs returns high.
- done  out  1  single-cycle pulse after a frame completes.

Behaviour:
- Reset values: spi_cs=1, spi_sclk=0, spi_mosi=0, spi_dc=0, rd=0, ssd1306_addr=0, busy=0, done=0, pending=0, state=IDLE.
- Edge detect: refresh_r registers refresh. (refresh & ~refresh_r) sets pending when IDLE. While busy, refresh edges are dropped, not queued.
- IDLE: done=0. If pending & gfx_ready, go to START, clear pending, busy=1.
- START (1 cycle): spi_cs=0, byte_cnt=0, go to LOAD_A.
- LOAD_A (1 cycle):
  - byte_cnt<6: select command ROM entry, spi_dc=0.
  - else: rd=1, ssd1306_addr=byte_cnt-6, spi_dc=1.
- LOAD_B (1 cycle):
  - rd stays high with the same address.
  - Capture ssd1306_out (or ROM byte) into shift_reg.
  - mosi=shift_reg MSB, bit_cnt=7, go to SHIFT.
  - rd returns to 0 on exit.
- SHIFT:
  - Per bit: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mosi changes only on the falling-edge cycle (sclk 1->0) and is stable while sclk is high.
  - After bit 0's high phase, sclk=0.
  - byte_cnt==CMD_BYTES+FB_BYTES-1: go to END. Else byte_cnt++, go to LOAD_A.
- END (1 cycle): spi_cs=1, spi_dc=0, busy=0, done=1, go to IDLE.
- Frame length from START: 2 + 518*(2+16*CLK_DIV) cycles. CLK_DIV=2 gives 17614.
- Command ROM, in order: 0x21, 0x00, 0x7F, 0x22, 0x00, 0x03 (column 0-127, page 0-3, horizontal addressing).
- Address: 9-bit, final value 511. No wrap is ever emitted.
- gfx_ready is sampled only in IDLE. The top level must gate render with busy; rd is asserted only in LOAD_A/LOAD_B.
- Reset mid-frame: next cycle all outputs take reset values (spi_cs=1). No done pulse.
- refresh edge in the same cycle as END: dropped, since busy is still high.

Decomposition:
- Package ssd1306_pkg: CMD_BYTES, FB_BYTES, command ROM constant array, state enum (IDLE, START, LOAD_A, LOAD_B, SHIFT, END).
- Sub-module spi_byte_tx: CLK_DIV timing, shift register, bit_cnt, start/done handshake. The parent owns the sequencing FSM and framebuffer reads.

Test Plan:
- Reset then one refresh pulse with gfx_ready=1, CLK_DIV=2 -> spi_cs low for exactly 17612 cycles; 518 bytes captured; first 6 = 21 00 7F 22 00 03 with dc=0; done pulses once.
- Framebuffer model preloaded addr0=0xA5, addr511=0x3C -> data byte 0 reads 10100101 and last byte reads 00111100, each sampled on sclk rising edges with dc=1.
- Read-port timing: rd high exactly 2 cycles per data byte; ssd1306_addr steps 0..511 with no gaps or repeats; rd=0 throughout the command bytes.
- gfx_ready=0 when refresh rises, raised 50 cycles later -> spi_cs falls 2 cycles after gfx_ready rises; no bytes lost.
- Second refresh edge mid-frame -> ignored; exactly one frame sent; no extra done.
- reset asserted during SHIFT of byte 100 -> next cycle spi_cs=1, sclk=0, busy=0; no done; a subsequent refresh sends a clean full frame.
